gyruss_sndcmd_tx: RTL

- Main-board side of the sound-command link to the Gyruss sound board.
- Queues 8-bit sound codes written by the main CPU and presents them one at a time as SNDNO. Issues a SNDRQ pulse whose rising edge the sound board latches.
- Waits for the sound CPU's interrupt-acknowledge before sending the next code, so back-to-back commands are never lost by overwriting the board's single latch.
- Sits between the main-CPU address decode and the sound board's SNDRQ/SNDNO inputs; all in the MCLK (49.152 MHz) domain.

---
 rtl/gyruss_snd_pkg.sv | 11 +
 rtl/gyruss_sndcmd_fifo.sv | 66 ++++++
 rtl/gyruss_sndcmd_tx.sv | 127 ++++++++++++
 3 files changed

// File: rtl/gyruss_snd_pkg.sv
// Shared types and default timing constants for the Gyruss sound-command link.
package gyruss_snd_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, WAIT_ACK} snd_state_e;

  localparam int SNDCMD_DEPTH_LOG2 = 3;
  localparam int SNDCMD_SETUP      = 4;
  localparam int SNDCMD_PULSE      = 16;
  localparam int SNDCMD_TIMEOUT    = 65535;

endpackage

// File: rtl/gyruss_sndcmd_fifo.sv
// Sound-code queue: registered level/full/empty, write accepted when full if a pop
// lands in the same cycle. sndreqrst is the async active-low reset.
module gyruss_sndcmd_fifo
  import gyruss_snd_pkg::*;
#(
  parameter int DEPTH_LOG2 = SNDCMD_DEPTH_LOG2
) (
  input  logic                  clk_in,
  input  logic                  sndreqrst,
  input  logic                  flush,
  input  logic                  wr,
  input  logic [7:0]            wdata,
  input  logic                  pop,
  output logic                  wr_ok,
  output logic [7:0]            rdata,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr, rptr;
  logic [DEPTH_LOG2:0]   level_nx;
  logic                  pop_ok;

  assign pop_ok = pop && !empty && !flush;
  assign wr_ok  = wr && !flush && (!full || pop_ok);
  assign rdata  = mem[rptr];

  always_comb begin
    level_nx = level;
    if (wr_ok && !pop_ok)      level_nx = level + 1'b1;
    else if (!wr_ok && pop_ok) level_nx = level - 1'b1;
  end

  always_ff @(posedge clk_in or negedge sndreqrst) begin
    if (!sndreqrst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      // pointers are exactly DEPTH_LOG2 wide, so wrap is free
      if (wr_ok)  wptr <= wptr + 1'b1;
      if (pop_ok) rptr <= rptr + 1'b1;
      level <= level_nx;
      full  <= (level_nx == LVL_FULL);
      empty <= (level_nx == '0);
    end
  end

  always_ff @(posedge clk_in) begin
    if (wr_ok) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/gyruss_sndcmd_tx.sv
// Main-board sound-command transmitter: queues CPU codes, strobes SNDRQ per code and
// holds off the next code until the sound CPU acknowledges (or a timeout expires).
module gyruss_sndcmd_tx
  import gyruss_snd_pkg::*;
#(
  parameter int DEPTH_LOG2  = SNDCMD_DEPTH_LOG2,
  parameter int SETUP_CYC   = SNDCMD_SETUP,
  parameter int PULSE_CYC   = SNDCMD_PULSE,
  parameter int TIMEOUT_CYC = SNDCMD_TIMEOUT
) (
  input  logic                MCLK,
  input  logic                RESET_N,
  input  logic                CMDWR,
  input  logic [7:0]          CMDDT,
  input  logic                FLUSH,
  input  logic                STCLR,
  input  logic                SNDACK,
  output logic                SNDRQ,
  output logic [7:0]          SNDNO,
  output logic                FULL,
  output logic                EMPTY,
  output logic                BUSY,
  output logic                OVF,
  output logic                TOUT,
  output logic [DEPTH_LOG2:0] LEVEL
);

  snd_state_e  state, state_nx;
  logic [7:0]  cnt, cnt_nx, sndno_nx, head;
  logic [15:0] tmo, tmo_nx;
  logic        sndrq_nx, pop, tout_set, wr_ok, ovf_set;
  logic [2:0]  ack_sync;
  logic        ack_p;

  gyruss_sndcmd_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk_in    (MCLK),
    .sndreqrst (RESET_N),
    .flush     (FLUSH),
    .wr        (CMDWR),
    .wdata     (CMDDT),
    .pop       (pop),
    .wr_ok     (wr_ok),
    .rdata     (head),
    .level     (LEVEL),
    .full      (FULL),
    .empty     (EMPTY)
  );

  // [1:0] is the two-flop synchroniser, [2] the previous sample for edge detect
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ack_sync <= '0;
      ack_p    <= 1'b0;
    end else begin
      ack_sync <= {ack_sync[1:0], SNDACK};
      ack_p    <= ack_sync[1] & ~ack_sync[2];
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    tmo_nx   = tmo;
    sndno_nx = SNDNO;
    sndrq_nx = SNDRQ;
    pop      = 1'b0;
    tout_set = 1'b0;
    if (FLUSH) begin
      state_nx = IDLE;
      sndrq_nx = 1'b0;
    end else begin
      case (state)
        IDLE: if (!EMPTY) begin
          sndno_nx = head;
          cnt_nx   = 8'(SETUP_CYC - 1);
          state_nx = SETUP;
        end
        SETUP: if (cnt == 8'd0) begin
          cnt_nx   = 8'(PULSE_CYC - 1);
          sndrq_nx = 1'b1;
          state_nx = PULSE;
        end else cnt_nx = cnt - 1'b1;
        PULSE: if (cnt == 8'd0) begin
          sndrq_nx = 1'b0;
          tmo_nx   = '0;
          state_nx = WAIT_ACK;
        end else cnt_nx = cnt - 1'b1;
        WAIT_ACK: if (ack_p) begin
          pop      = 1'b1;
          state_nx = IDLE;
        end else if (tmo == 16'(TIMEOUT_CYC - 1)) begin
          pop      = 1'b1;
          tout_set = 1'b1;
          state_nx = IDLE;
        end else tmo_nx = tmo + 1'b1;
        default: state_nx = IDLE;
      endcase
    end
  end

  // a write swallowed by FLUSH is intentional, not an overflow
  assign ovf_set = CMDWR && !FLUSH && !wr_ok;
  assign BUSY    = (state != IDLE);

  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
      cnt   <= '0;
      tmo   <= '0;
      SNDNO <= 8'h00;
      SNDRQ <= 1'b0;
      OVF   <= 1'b0;
      TOUT  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      tmo   <= tmo_nx;
      SNDNO <= sndno_nx;
      SNDRQ <= sndrq_nx;
      if (ovf_set)    OVF <= 1'b1;
      else if (STCLR) OVF <= 1'b0;
      if (tout_set)   TOUT <= 1'b1;
      else if (STCLR) TOUT <= 1'b0;
    end
  end

endmodule
